tiny_nn_ctrl: RTL and testbench

// Parametrised command sequencer for the tiny_nn compute core. Decodes 16-bit commands and operands
// on data_i and drives the core's parameter-write, value-shift, multiply and accumulate controls.

---
 rtl/tiny_nn_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_tiny_nn_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_nn_ctrl.sv
// Command sequencer for the tiny_nn compute core: decodes the data_i stream into parameter-write,
// value-shift, multiply and accumulate controls and serialises core results onto an 8-bit bus.
module tiny_nn_ctrl #(
  parameter int unsigned CountWidth     = 8,
  parameter int unsigned ValArrayWidth  = 4,
  parameter int unsigned ValArrayHeight = 2,
  parameter int unsigned DrainCycles    = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [15:0]                       data_i,
  input  logic [15:0]                       core_result_i,
  output logic [7:0]                        data_o,
  output logic [ValArrayWidth*ValArrayHeight-1:0] param_write_o,
  output logic [ValArrayHeight-1:0]         val_shift_o,
  output logic [$clog2(ValArrayHeight)-1:0] mul_row_sel_o,
  output logic                              mul_en_o,
  output logic [1:0]                        accumulate_en_o,
  output logic                              acc_loopback_o,
  output logic                              acc_out_relu_o,
  output logic [1:0]                        acc_direct_en_o,
  output logic                              busy_o
);

  localparam int unsigned NumParams = ValArrayWidth * ValArrayHeight;
  localparam int unsigned PhaseW    = $clog2(ValArrayHeight);

  localparam logic [3:0]  CmdOpConvolve   = 4'h1;
  localparam logic [3:0]  CmdOpAccumulate = 4'h2;
  localparam logic [15:0] FPStdNaN        = 16'h7FC0;

  typedef enum logic [2:0] {
    Idle, ParamIn, ConvExec, ConvEnd, BiasIn, AccExec, AccEnd1, AccEnd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PhaseW-1:0]       phase_q, phase_d;
  logic [CountWidth-1:0]   counter_q, counter_d;
  logic [CountWidth-1:0]   start_count_q, start_count_d;
  logic [NumParams-1:0]    param_write_q, param_write_d;
  logic                    relu_q, relu_d;
  logic [7:0]              skid_q, skid_d;

  logic [ValArrayHeight-1:0] row_hit;
  logic [PhaseW-1:0]         phase_next;
  logic [CountWidth-1:0]     cmd_count;
  logic                      in_nan;

  for (genvar r = 0; r < ValArrayHeight; r++) begin : g_row
    assign row_hit[r] = (phase_q == PhaseW'(r));
  end

  assign phase_next = (phase_q == PhaseW'(ValArrayHeight - 1)) ? '0 : phase_q + PhaseW'(1);
  assign cmd_count  = data_i[CountWidth-1:0];
  assign in_nan     = (data_i == FPStdNaN);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= Idle;
      phase_q       <= '0;
      counter_q     <= '0;
      start_count_q <= '0;
      param_write_q <= '0;
      relu_q        <= 1'b0;
      skid_q        <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      counter_q     <= counter_d;
      start_count_q <= start_count_d;
      param_write_q <= param_write_d;
      relu_q        <= relu_d;
      skid_q        <= skid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    counter_d       = counter_q;
    start_count_d   = start_count_q;
    param_write_d   = param_write_q;
    relu_d          = relu_q;
    skid_d          = skid_q;
    data_o          = 8'hFF;
    param_write_o   = '0;
    val_shift_o     = '0;
    mul_row_sel_o   = '0;
    mul_en_o        = 1'b0;
    accumulate_en_o = 2'b00;
    acc_loopback_o  = 1'b0;
    acc_out_relu_o  = 1'b0;
    acc_direct_en_o = 2'b00;
    busy_o          = (state_q != Idle);

    unique case (state_q)
      Idle: begin
        if (data_i[15:12] == CmdOpConvolve) begin
          if (data_i[8]) begin
            state_d = ConvExec;
            phase_d = '0;
          end else begin
            state_d       = ParamIn;
            param_write_d = NumParams'(1);
          end
        end else if (data_i[15:12] == CmdOpAccumulate) begin
          // A zero count would never reload away from zero, so treat it as one.
          start_count_d = (cmd_count == '0) ? CountWidth'(1) : cmd_count;
          counter_d     = CountWidth'(1);
          relu_d        = data_i[8];
          state_d       = BiasIn;
        end
      end

      ParamIn: begin
        param_write_o = param_write_q;
        param_write_d = param_write_q << 1;
        if (param_write_q[NumParams-1]) begin
          state_d = ConvExec;
          phase_d = '0;
        end
      end

      ConvExec, ConvEnd: begin
        val_shift_o        = row_hit;
        mul_row_sel_o      = phase_q;
        mul_en_o           = 1'b1;
        accumulate_en_o[0] = 1'b1;
        accumulate_en_o[1] = (phase_q == PhaseW'(ValArrayHeight - 1));
        phase_d            = phase_next;
        if (phase_q == '0)                data_o = core_result_i[7:0];
        else if (phase_q == PhaseW'(1))   data_o = core_result_i[15:8];
        if (state_q == ConvExec) begin
          if (in_nan) begin
            state_d   = ConvEnd;
            counter_d = CountWidth'(DrainCycles);
          end
        end else if (counter_q != '0) begin
          counter_d = counter_q - CountWidth'(1);
        end else begin
          state_d = Idle;
        end
      end

      BiasIn: begin
        acc_direct_en_o[1] = 1'b1;
        state_d            = AccExec;
      end

      AccExec: begin
        accumulate_en_o[1] = 1'b1;
        acc_direct_en_o[0] = 1'b1;
        // Result cycle: low byte goes out now, high byte is held for the next cycle.
        if (counter_q == '0) begin
          counter_d = start_count_q;
          skid_d    = core_result_i[15:8];
          data_o    = core_result_i[7:0];
        end else begin
          acc_loopback_o = 1'b1;
          acc_out_relu_o = relu_q & (counter_q == CountWidth'(1));
          counter_d      = counter_q - CountWidth'(1);
          data_o         = skid_q;
        end
        if (in_nan) state_d = AccEnd1;
      end

      AccEnd1: begin
        skid_d  = core_result_i[15:8];
        data_o  = core_result_i[7:0];
        state_d = AccEnd2;
      end

      AccEnd2: begin
        data_o  = skid_q;
        state_d = Idle;
      end

      default: state_d = Idle;
    endcase
  end

endmodule

// File: tb/tb_tiny_nn_ctrl.sv
// Directed bench for tiny_nn_ctrl: a default-parameter instance plus an H=3 instance sharing inputs.
module tb_tiny_nn_ctrl;

  localparam logic [15:0] CONV = 16'h1000;
  localparam logic [15:0] ACC  = 16'h2000;
  localparam logic [15:0] NAN  = 16'h7FC0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din, res;

  logic [7:0] a_data, a_pw;
  logic [1:0] a_vs, a_acc, a_dir;
  logic [0:0] a_mrs;
  logic       a_mul, a_lb, a_relu, a_busy;

  logic [7:0]  b_data;
  logic [11:0] b_pw;
  logic [2:0]  b_vs;
  logic [1:0]  b_mrs, b_acc, b_dir;
  logic        b_mul, b_lb, b_relu, b_busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tiny_nn_ctrl u_a (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din), .core_result_i(res), .data_o(a_data),
    .param_write_o(a_pw), .val_shift_o(a_vs), .mul_row_sel_o(a_mrs), .mul_en_o(a_mul),
    .accumulate_en_o(a_acc), .acc_loopback_o(a_lb), .acc_out_relu_o(a_relu),
    .acc_direct_en_o(a_dir), .busy_o(a_busy)
  );

  tiny_nn_ctrl #(.ValArrayHeight(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din), .core_result_i(res), .data_o(b_data),
    .param_write_o(b_pw), .val_shift_o(b_vs), .mul_row_sel_o(b_mrs), .mul_en_o(b_mul),
    .accumulate_en_o(b_acc), .acc_loopback_o(b_lb), .acc_out_relu_o(b_relu),
    .acc_direct_en_o(b_dir), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " ctl"}, 32'({a_pw, a_vs, a_mrs, a_mul, a_acc, a_lb, a_relu, a_dir, a_busy}), 32'd0);
    chk({tag, " data"}, 32'(a_data), 32'hFF);
  endtask

  task automatic chk_idle_b(input string tag);
    chk({tag, " ctl"}, 32'({b_pw, b_vs, b_mrs, b_mul, b_acc, b_lb, b_relu, b_dir, b_busy}), 32'd0);
    chk({tag, " data"}, 32'(b_data), 32'hFF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    din   = 16'h0000;
    #1;
  endtask

  initial begin
    int lb3[7]   = '{1, 0, 1, 1, 1, 0, 1};
    int relu3[7] = '{1, 0, 0, 0, 1, 0, 0};
    int d3[7]    = '{'h00, 'hCD, 'hAB, 'hAB, 'hAB, 'hCD, 'hAB};
    int p;
    rst_n = 1'b0;
    din   = 16'h0000;
    res   = 16'h0000;
    step();
    do_reset();
    chk_idle_a("reset_a");
    chk_idle_b("reset_b");

    // Convolve with parameter load, default geometry
    din = CONV; #1;
    chk("conv_cmd busy", 32'(a_busy), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      din = 16'h3C00 + 16'(i); #1;
      chk($sformatf("param_write[%0d]", i), 32'(a_pw), 32'(1) << i);
      chk($sformatf("param data[%0d]", i), 32'(a_data), 32'hFF);
      step();
    end
    res = 16'h1234;
    for (int k = 0; k < 6; k++) begin
      din = 16'h0100 + 16'(k); #1;
      chk($sformatf("exec vs[%0d]", k), 32'(a_vs), (k % 2 == 0) ? 1 : 2);
      chk($sformatf("exec acc[%0d]", k), 32'(a_acc), (k % 2 == 0) ? 1 : 3);
      chk($sformatf("exec sel/mul/pw[%0d]", k), 32'({a_mrs, a_mul, a_pw}), 32'({k % 2 == 1, 1'b1, 8'h00}));
      chk($sformatf("exec data[%0d]", k), 32'(a_data), (k % 2 == 0) ? 32'h34 : 32'h12);
      step();
    end
    din = NAN; #1;
    chk("nan cycle vs", 32'(a_vs), 1);
    step();
    for (int d = 0; d < 5; d++) begin
      din = 16'h0000; #1;
      chk($sformatf("drain busy[%0d]", d), 32'(a_busy), 1);
      chk($sformatf("drain vs[%0d]", d), 32'(a_vs), (d % 2 == 0) ? 2 : 1);
      step();
    end
    chk_idle_a("after_drain");

    // Reset while in ParamIn at bit 3
    din = CONV; step();
    for (int i = 0; i < 3; i++) begin din = 16'h4000; step(); end
    #1;
    chk("paramin bit3", 32'(a_pw), 32'h08);
    do_reset();
    chk_idle_a("reset_paramin");

    // Reused-parameter convolve, then reset mid-drain
    din = CONV | 16'h0100; #1;
    step();
    chk("reuse no paramin", 32'({a_pw, a_mul}), 32'h1);
    din = NAN; step();
    din = 16'h0000; step();
    chk("mid_drain busy", 32'(a_busy), 1);
    do_reset();
    chk_idle_a("reset_drain");

    // Unknown opcodes are ignored
    din = 16'h5000; step();
    chk_idle_a("unknown_5");
    din = 16'hF1FF; step();
    chk_idle_a("unknown_F");

    // Accumulate count=3 with ReLU
    res = 16'hABCD;
    din = ACC | 16'h0100 | 16'd3; step();
    din = 16'h3F80; #1;
    chk("bias dir", 32'(a_dir), 2);
    chk("bias acc/data", 32'({a_acc, a_data}), 32'h0FF);
    step();
    for (int j = 0; j < 7; j++) begin
      din = 16'h0200 + 16'(j); #1;
      chk($sformatf("acc3 lb[%0d]", j), 32'(a_lb), 32'(lb3[j]));
      chk($sformatf("acc3 relu[%0d]", j), 32'(a_relu), 32'(relu3[j]));
      chk($sformatf("acc3 data[%0d]", j), 32'(a_data), 32'(d3[j]));
      chk($sformatf("acc3 en[%0d]", j), 32'({a_acc, a_dir}), 32'b1001);
      step();
    end
    din = NAN; #1;
    chk("acc3 nan lb", 32'({a_lb, a_data}), 32'h1AB);
    step();
    res = 16'h5566; din = 16'h0000; #1;
    chk("accend1 data", 32'(a_data), 32'h66);
    chk("accend1 ctl", 32'({a_lb, a_acc, a_dir, a_busy}), 32'h1);
    step();
    chk("accend2 data", 32'({a_data, a_busy}), 32'h0AB);
    step();
    chk_idle_a("acc3_done");

    // Reset in AccExec (count 0 clamped, relu on)
    din = ACC | 16'h0100; step();
    din = 16'h0000; step();
    chk("accexec relu", 32'({a_lb, a_relu, a_data}), 32'h355);
    do_reset();
    chk_idle_a("reset_accexec");

    // Count=0 behaves as count=1; NaN on the result cycle
    res = 16'h1122;
    din = ACC; step();
    din = 16'h0000; step();
    din = 16'h0001; #1;
    chk("acc0 c0", 32'({a_lb, a_relu, a_data}), 32'h200);
    step();
    chk("acc0 c1", 32'({a_lb, a_data}), 32'h022);
    step();
    chk("acc0 c2", 32'({a_lb, a_data}), 32'h111);
    step();
    din = NAN; #1;
    chk("acc0 c3", 32'({a_lb, a_data}), 32'h022);
    step();
    din = 16'h0000; #1;
    chk("acc0 end1", 32'({a_data, a_busy}), 32'h045);
    step();
    chk("acc0 end2", 32'({a_data, a_busy}), 32'h023);
    step();
    chk_idle_a("acc0_done");

    // Three-row instance, reused parameters
    do_reset();
    res = 16'hBEEF;
    din = CONV | 16'h0100; #1;
    chk("h3 cmd busy", 32'(b_busy), 0);
    step();
    for (int k = 0; k < 6; k++) begin
      p = k % 3;
      din = 16'h0200 + 16'(k); #1;
      chk($sformatf("h3 pw[%0d]", k), 32'(b_pw), 0);
      chk($sformatf("h3 vs[%0d]", k), 32'(b_vs), 32'(1) << p);
      chk($sformatf("h3 sel[%0d]", k), 32'({b_mrs, b_mul}), 32'((p << 1) | 1));
      chk($sformatf("h3 acc[%0d]", k), 32'(b_acc), (p == 2) ? 3 : 1);
      chk($sformatf("h3 data[%0d]", k), 32'(b_data), (p == 0) ? 32'hEF : (p == 1) ? 32'hBE : 32'hFF);
      step();
    end
    do_reset();
    chk_idle_b("h3_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
